regfile_wb_ctrl: RTL

Writeback controller for the 32×32 register file: it shares the file's single write port between the ALU and LSU writeback paths and tracks outstanding writes in a scoreboard. It sits between the execute/memory stages and the register file write port (`reg_write`, `rd_addr`, `write_data`). It also supplies `rs1`/`rs2` busy flags to the issue stage for RAW stalls and blocks WAW issue.

---
 rtl/brisc_pkg.sv | 12 +
 rtl/wb_scoreboard.sv | 36 +++
 rtl/regfile_wb_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/brisc_pkg.sv
// Shared core definitions: register-file geometry and the writeback request record.
package brisc_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap: set at issue, cleared at commit, looked up for WAW/RAW checks.
module wb_scoreboard
  import brisc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  commit_valid,
  input  logic [REG_ADDR_W-1:0] commit_rd,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);
  // Bit 0 is kept at zero in the register so x0 lookups need no special case.
  logic [NUM_REGS-1:0] pending, set_vec, clr_vec;

  assign issue_ready = (issue_rd == '0) | ~pending[issue_rd];
  assign rs1_busy    = pending[rs1_addr];
  assign rs2_busy    = pending[rs2_addr];

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_ready && issue_rd != '0) set_vec[issue_rd] = 1'b1;
    if (commit_valid && commit_rd != '0)              clr_vec[commit_rd] = 1'b1;
  end

  // Set is ORed after the clear so a same-cycle set on the committing index survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= ((pending & ~clr_vec) | set_vec) & ~NUM_REGS'(1);
  end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU/LSU onto the single register-file write port
// with anti-starvation for the ALU, and tracks outstanding writes for issue.
module regfile_wb_ctrl #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             alu_valid,
  input  logic [brisc_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                  alu_data,
  output logic                             alu_ready,
  input  logic                             lsu_valid,
  input  logic [brisc_pkg::REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]                  lsu_data,
  output logic                             lsu_ready,
  input  logic                             issue_valid,
  input  logic [brisc_pkg::REG_ADDR_W-1:0] issue_rd,
  output logic                             issue_ready,
  input  logic [brisc_pkg::REG_ADDR_W-1:0] rs1_addr,
  input  logic [brisc_pkg::REG_ADDR_W-1:0] rs2_addr,
  output logic                             rs1_busy,
  output logic                             rs2_busy,
  output logic                             reg_write,
  output logic [brisc_pkg::REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]                  write_data
);
  import brisc_pkg::REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } req_t;

  localparam int WCW = 4;

  logic [WCW-1:0] wait_cnt;
  logic           alu_gnt, lsu_gnt;
  req_t           win;

  // LSU has priority unless the ALU has been denied MAX_WAIT cycles in a row.
  assign alu_gnt   = ~rst & alu_valid & ((wait_cnt == WCW'(MAX_WAIT)) | ~lsu_valid);
  assign lsu_gnt   = ~rst & lsu_valid & ~alu_gnt;
  assign alu_ready = alu_gnt;
  assign lsu_ready = lsu_gnt;

  always_comb begin
    win       = '0;
    win.valid = alu_gnt | lsu_gnt;
    win.rd    = alu_gnt ? alu_rd   : lsu_rd;
    win.data  = alu_gnt ? alu_data : lsu_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          wait_cnt <= '0;
    else if (!alu_valid || alu_gnt)   wait_cnt <= '0;
    else if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
  end

  // x0 writes are accepted and captured but never strobe the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      rd_addr    <= '0;
      write_data <= '0;
    end else begin
      reg_write <= win.valid && (win.rd != '0);
      if (win.valid) begin
        rd_addr    <= win.rd;
        write_data <= win.data;
      end
    end
  end

  wb_scoreboard u_sb (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .commit_valid (reg_write),
    .commit_rd    (rd_addr),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy)
  );
endmodule
